timer_peripheral: RTL and testbench
===================================

# timer_peripheral

Memory-mapped interval timer on the data-memory bus of `single_cycle_core`.
- Decodes the core's `oMemAddr`/`oMemRead`/`oMemWrite`/`oMemWriteData`.
- Returns register data for the bus read mux feeding `iMemReadData`.
- Drives the core's `iInterrupt` from a reload-on-overflow counter.
- Registers are read combinationally so a single-cycle load completes in the same cycle. Writes commit on the clock edge.

## Interface
- `BASE_ADDR`, 32'h40000000: word address of the TH register. Bits [3:0] must be zero.
- `clk` in 1: system clock, shared with the core.
- `reset` in 1: asynchronous, active-low reset.
- `iAddr` in 32: bus address, from `oMemAddr`.
- `iRead` in 1: bus read strobe, from `oMemRead`.
- `iWrite` in 1: bus write strobe, from `oMemWrite`.
- `iWdata` in 32: bus write data, from `oMemWriteData`.
- `oRdata` out 32: read data. Zero when not selected or `iRead`=0.
- `oHit` out 1: address falls in this block's 16-byte window. Used by the bus read mux.
- `oIrq` out 1: interrupt request (TCON[2]). Connects to `iInterrupt`.

## Operation
- Hit condition: `iAddr[31:4] == BASE_ADDR[31:4]`. `iAddr[1:0]` is ignored.
- Register offsets:
  - 0x0 TH: reload value, R/W.
  - 0x4 TL: counter, R/W.
  - 0x8 TCON: bit0 = run enable, bit1 = interrupt enable, bit2 = interrupt status. Bits [31:3] read 0 and ignore writes.
  - 0xC PRE: prescale value, low 16 bits R/W, upper bits read 0.
- Write: on the rising edge with `iWrite`=1 and hit, the selected register takes `iWdata` (masked as above). Software clears the interrupt by writing TCON with bit2=0.
- Read: `oRdata` is the selected register when `iRead`=1 and hit, else 0.
- Prescaler: 16-bit counter `pcnt`, advances only while TCON[0]=1.
  - If `pcnt==PRE`: `pcnt`←0 and a one-cycle `tick` fires.
  - Otherwise `pcnt`←`pcnt`+1.
  - A write to PRE forces `pcnt`←0.
- Counter, on `tick`:
  - If TL==32'hFFFFFFFF: TL←TH, and if TCON[1]=1 then TCON[2]←1.
  - Otherwise TL←TL+1.
- Clearing TCON[0] freezes TL and `pcnt` at their current values. Nothing is reset by it.
- `oIrq` = TCON[2]. It is a level signal, held until software clears it.

## Timing
- Reset (asynchronous, while `reset`=0): TH, TL, TCON, PRE and `pcnt` all go to 0.
  - Hence `oIrq`=0.
  - `oRdata` and `oHit` are combinational and follow the inputs.
- Read latency 0: `oRdata` is valid in the same cycle as the address.
- Write latency 1: the new value is visible on the cycle after the edge.
- Overflow to `oIrq` latency: `oIrq` rises on the edge where TL reloads.
- Simultaneous bus write to TL and tick on the same edge: the bus write wins; no increment or reload.
- Simultaneous TCON write with bit2=0 and an overflow that sets bit2 on the same edge: the set wins, so `oIrq` stays 1 and no interrupt is lost. Bits 0–1 still take `iWdata`.
- Write to TH on an overflow edge: the reload uses the old TH.
- Write to TCON enabling the timer: counting starts on the following edge.
- Reset asserted mid-count: immediate return to reset values. The counter restarts only after software re-enables it.
- Hit with both `iRead`=0 and `iWrite`=0: no state change, `oRdata`=0.

## Configuration
- `TIMER_PRESCALE_EN` defined: PRE register and `pcnt` are implemented as described above.
- `TIMER_PRESCALE_EN` undefined: no PRE or `pcnt` storage.
  - Offset 0xC reads 0 and ignores writes.
  - `tick` = TCON[0], i.e. TL advances every cycle while running.

## Test plan
- Reset: hold `reset`=0 with TCON previously 3'b111 → `oIrq`=0. After release, reads of all four offsets return 0.
- Basic overflow, PRE=0:
  - Setup: write TH=32'hFFFFFFFC, TL=32'hFFFFFFFE, TCON=3.
  - After 2 edges TL=32'hFFFFFFFC and `oIrq`=1.
  - After 4 more edges TL=32'hFFFFFFFC again.
- Prescale (`TIMER_PRESCALE_EN`):
  - Setup: PRE=3, TL=0, TCON=1.
  - After 12 edges TL=3. After 2 more edges TL is still 3.
  - Without the macro: TL=12 after 12 edges, and a read of 0xC returns 0.
- Collision:
  - Write TL=5 on the edge where TL would wrap → TL=5, no reload, `oIrq` unchanged.
  - Write TCON=3 on an overflow edge with TCON[1]=1 → TCON reads 7.
- Freeze: with TL=100 and TCON=1, write TCON=0 → TL stays 100 for 50 cycles. `oRdata` at offset 0x4 = 100 with `iRead`=1.
- Decode: access `BASE_ADDR`+0x10 → `oHit`=0, `oRdata`=0, no register changes. Address `BASE_ADDR`+0x6 aliases TL.

Source files
------------

// File: rtl/timer_peripheral_if.sv
// Data-memory bus connection between single_cycle_core and timer_peripheral.
// The core drives the request side; the timer returns read data, hit and interrupt.
interface timer_peripheral_if;
    logic [31:0] iAddr;
    logic        iRead;
    logic        iWrite;
    logic [31:0] iWdata;
    logic [31:0] oRdata;
    logic        oHit;
    logic        oIrq;

    modport master (
        output iAddr,
        output iRead,
        output iWrite,
        output iWdata,
        input  oRdata,
        input  oHit,
        input  oIrq
    );

    modport slave (
        input  iAddr,
        input  iRead,
        input  iWrite,
        input  iWdata,
        output oRdata,
        output oHit,
        output oIrq
    );
endinterface

// File: rtl/timer_peripheral.sv
// Memory-mapped interval timer (TH/TL/TCON/PRE) with reload-on-overflow and level interrupt.
// Optional prescaler (PRE register and pcnt) is built only when TIMER_PRESCALE_EN is defined.
module timer_peripheral #(
    parameter logic [31:0] BASE_ADDR = 32'h40000000
) (
    input logic          clk,
    input logic          reset,
    timer_peripheral_if.slave bus
);

    logic        hit;
    logic [1:0]  sel;
    logic        wr_th, wr_tl, wr_tcon, wr_pre;
    logic        tick;
    logic        overflow;
    logic        irq_set;

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;

    logic        unused_addr;
    assign unused_addr = ^bus.iAddr[1:0];

    assign hit     = (bus.iAddr[31:4] == BASE_ADDR[31:4]);
    assign sel     = bus.iAddr[3:2];
    assign wr_th   = bus.iWrite && hit && (sel == 2'd0);
    assign wr_tl   = bus.iWrite && hit && (sel == 2'd1);
    assign wr_tcon = bus.iWrite && hit && (sel == 2'd2);
    assign wr_pre  = bus.iWrite && hit && (sel == 2'd3);

`ifdef TIMER_PRESCALE_EN
    logic [15:0] pre_q, pre_d;
    logic [15:0] pcnt_q, pcnt_d;

    assign tick = tcon_q[0] && (pcnt_q == pre_q);

    always_comb begin
        pre_d  = pre_q;
        pcnt_d = pcnt_q;
        if (wr_pre) begin
            pre_d = bus.iWdata[15:0];
        end
        // A PRE write restarts the prescale period regardless of run state.
        if (wr_pre) begin
            pcnt_d = 16'd0;
        end else if (tcon_q[0]) begin
            pcnt_d = (pcnt_q == pre_q) ? 16'd0 : pcnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q  <= 16'd0;
            pcnt_q <= 16'd0;
        end else begin
            pre_q  <= pre_d;
            pcnt_q <= pcnt_d;
        end
    end
`else
    logic unused_wr_pre;
    assign unused_wr_pre = wr_pre;
    assign tick = tcon_q[0];
`endif

    always_comb begin
        th_d     = wr_th ? bus.iWdata : th_q;
        tl_d     = tl_q;
        overflow = 1'b0;
        // Bus write to TL takes priority over any increment or reload on the same edge.
        if (wr_tl) begin
            tl_d = bus.iWdata;
        end else if (tick) begin
            if (&tl_q) begin
                tl_d     = th_q;
                overflow = 1'b1;
            end else begin
                tl_d = tl_q + 32'd1;
            end
        end
    end

    assign irq_set = overflow && tcon_q[1];

    always_comb begin
        tcon_d = tcon_q;
        if (wr_tcon) begin
            tcon_d = bus.iWdata[2:0];
        end
        // Hardware set beats a simultaneous software clear so no interrupt is lost.
        if (irq_set) begin
            tcon_d[2] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th_q   <= 32'd0;
            tl_q   <= 32'd0;
            tcon_q <= 3'd0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
        end
    end

    always_comb begin
        bus.oRdata = 32'd0;
        if (bus.iRead && hit) begin
            case (sel)
                2'd0:    bus.oRdata = th_q;
                2'd1:    bus.oRdata = tl_q;
                2'd2:    bus.oRdata = {29'd0, tcon_q};
`ifdef TIMER_PRESCALE_EN
                default: bus.oRdata = {16'd0, pre_q};
`else
                default: bus.oRdata = 32'd0;
`endif
            endcase
        end
    end

    assign bus.oHit = hit;
    assign bus.oIrq = tcon_q[2];

endmodule

// File: tb/tb_timer_peripheral.sv
// Directed self-checking bench for timer_peripheral; expectations adapt to TIMER_PRESCALE_EN.
module tb_timer_peripheral;

    localparam logic [31:0] Base = 32'h40000000;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [31:0] d;

    timer_peripheral_if bus_if ();

    timer_peripheral #(.BASE_ADDR(Base)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Write is set up on the falling edge and commits on the next rising edge.
    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus_if.iAddr  = addr;
        bus_if.iWdata = data;
        bus_if.iWrite = 1'b1;
        @(posedge clk);
        #1;
        bus_if.iWrite = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        bus_if.iAddr = addr;
        bus_if.iRead = 1'b1;
        #1;
        data = bus_if.oRdata;
        bus_if.iRead = 1'b0;
        #1;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        bus_if.iAddr  = 32'd0;
        bus_if.iRead  = 1'b0;
        bus_if.iWrite = 1'b0;
        bus_if.iWdata = 32'd0;
        edges(2);
        @(negedge clk);
        reset = 1'b1;

        // Reset with TCON = 7
        wr(Base + 32'h8, 32'h7);
        check("irq_set_by_sw", {31'd0, bus_if.oIrq}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("irq_in_reset", {31'd0, bus_if.oIrq}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        rd(Base + 32'h0, d); check("rst_th", d, 32'd0);
        rd(Base + 32'h4, d); check("rst_tl", d, 32'd0);
        rd(Base + 32'h8, d); check("rst_tcon", d, 32'd0);
        rd(Base + 32'hC, d); check("rst_pre", d, 32'd0);

        // Basic overflow with PRE = 0
        wr(Base + 32'h0, 32'hFFFFFFFC);
        wr(Base + 32'h4, 32'hFFFFFFFE);
        wr(Base + 32'h8, 32'h3);
        edges(2);
        rd(Base + 32'h4, d); check("ovf_tl_reload", d, 32'hFFFFFFFC);
        check("ovf_irq", {31'd0, bus_if.oIrq}, 32'd1);
        rd(Base + 32'h8, d); check("ovf_tcon", d, 32'h7);
        edges(4);
        rd(Base + 32'h4, d); check("ovf_tl_second", d, 32'hFFFFFFFC);
        wr(Base + 32'h8, 32'h0);
        check("irq_cleared", {31'd0, bus_if.oIrq}, 32'd0);

        // TL write collides with the wrap edge
        wr(Base + 32'h0, 32'h10);
        wr(Base + 32'h4, 32'hFFFFFFFE);
        wr(Base + 32'h8, 32'h3);
        edges(1);
        wr(Base + 32'h4, 32'h5);
        rd(Base + 32'h4, d); check("coll_tl_wins", d, 32'h5);
        check("coll_tl_no_irq", {31'd0, bus_if.oIrq}, 32'd0);
        wr(Base + 32'h8, 32'h0);

        // TCON clear collides with an overflow that sets the interrupt
        wr(Base + 32'h0, 32'h20);
        wr(Base + 32'h4, 32'hFFFFFFFE);
        wr(Base + 32'h8, 32'h3);
        edges(1);
        wr(Base + 32'h8, 32'h3);
        rd(Base + 32'h8, d); check("coll_tcon_set_wins", d, 32'h7);
        rd(Base + 32'h4, d); check("coll_tcon_reload", d, 32'h20);
        wr(Base + 32'h8, 32'h0);
        check("irq_cleared2", {31'd0, bus_if.oIrq}, 32'd0);

        // TH write on the overflow edge: reload uses old TH
        wr(Base + 32'h0, 32'h30);
        wr(Base + 32'h4, 32'hFFFFFFFE);
        wr(Base + 32'h8, 32'h1);
        edges(1);
        wr(Base + 32'h0, 32'h40);
        rd(Base + 32'h4, d); check("th_coll_old_reload", d, 32'h30);
        rd(Base + 32'h0, d); check("th_coll_new_th", d, 32'h40);
        check("th_coll_no_irq_ie0", {31'd0, bus_if.oIrq}, 32'd0);
        wr(Base + 32'h8, 32'h0);

        // Freeze: TL written 99 while running, stop edge takes it to 100
        wr(Base + 32'h8, 32'h1);
        wr(Base + 32'h4, 32'd99);
        wr(Base + 32'h8, 32'h0);
        rd(Base + 32'h4, d); check("freeze_tl_start", d, 32'd100);
        edges(50);
        rd(Base + 32'h4, d); check("freeze_tl_50", d, 32'd100);
        bus_if.iAddr = Base + 32'h4;
        #1;
        check("no_read_rdata0", bus_if.oRdata, 32'd0);
        check("no_read_hit", {31'd0, bus_if.oHit}, 32'd1);

        // Prescale
        wr(Base + 32'hC, 32'hFFFF0003);
        wr(Base + 32'h4, 32'd0);
        wr(Base + 32'h8, 32'h1);
        edges(12);
        rd(Base + 32'h4, d);
`ifdef TIMER_PRESCALE_EN
        check("pre_tl_12", d, 32'd3);
`else
        check("pre_tl_12", d, 32'd12);
`endif
        edges(2);
        rd(Base + 32'h4, d);
`ifdef TIMER_PRESCALE_EN
        check("pre_tl_14", d, 32'd3);
`else
        check("pre_tl_14", d, 32'd14);
`endif
        rd(Base + 32'hC, d);
`ifdef TIMER_PRESCALE_EN
        check("pre_read", d, 32'h3);
`else
        check("pre_read", d, 32'h0);
`endif
        wr(Base + 32'h8, 32'h0);

        // Decode
        wr(Base + 32'h4, 32'h1234);
        wr(Base + 32'h10, 32'hDEAD);
        bus_if.iAddr = Base + 32'h10;
        bus_if.iRead = 1'b1;
        #1;
        check("miss_hit", {31'd0, bus_if.oHit}, 32'd0);
        check("miss_rdata", bus_if.oRdata, 32'd0);
        bus_if.iRead = 1'b0;
        rd(Base + 32'h4, d); check("miss_tl_kept", d, 32'h1234);
        rd(Base + 32'h0, d); check("miss_th_kept", d, 32'h40);
        rd(Base + 32'h6, d); check("alias_rd_tl", d, 32'h1234);
        wr(Base + 32'h7, 32'h55);
        rd(Base + 32'h4, d); check("alias_wr_tl", d, 32'h55);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
